pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer for a single-cycle processor.
//               Holds the current instruction address, advances it by one
//               instruction per cycle from the PC-update stage, stops on halt
//               or on an instruction/data fault, and counts RUN cycles.
//               Optional retired-instruction counter is enabled by defining
//               the macro PC_RETIRE_COUNT_EN.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, start_pc     - begin execution at start_pc (non-RUN)
//               updated_pc          - next PC for the current instruction
//               icode               - current icode (0 = halt)
//               instr_valid         - fetch saw a legal instruction
//               imem_error          - fetch address fault at pc
//               dmem_error          - data-memory address fault
//               pc                  - current instruction address
//               commit              - current instruction may write state
//               stat                - 0 idle, 1 AOK, 2 HLT, 3 ADR, 4 INS
//               cycle_count         - cycles spent in RUN since start
//               retired_count       - committed instructions since start
//                                     (PC_RETIRE_COUNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] start_pc,
    input  logic [63:0] updated_pc,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    output logic [63:0] pc,
    output logic        commit,
    output logic [2:0]  stat,
    output logic [63:0] cycle_count
`ifdef PC_RETIRE_COUNT_EN
    ,
    output logic [63:0] retired_count
`endif
);

    localparam logic [2:0] C_STAT_IDLE = 3'd0;
    localparam logic [2:0] C_STAT_AOK  = 3'd1;
    localparam logic [2:0] C_STAT_HLT  = 3'd2;
    localparam logic [2:0] C_STAT_ADR  = 3'd3;
    localparam logic [2:0] C_STAT_INS  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_pc;
    logic [63:0] w_pc_next;
    logic [2:0]  r_fault_code;
    logic [2:0]  w_fault_next;
    logic [63:0] r_cycle_count;
    logic [63:0] w_cycle_next;
    logic        w_commit;
`ifdef PC_RETIRE_COUNT_EN
    logic [63:0] r_retired_count;
    logic [63:0] w_retired_next;
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pc            <= 64'd0;
            r_fault_code    <= C_STAT_IDLE;
            r_cycle_count   <= 64'd0;
`ifdef PC_RETIRE_COUNT_EN
            r_retired_count <= 64'd0;
`endif
        end else begin
            r_state         <= w_state_next;
            r_pc            <= w_pc_next;
            r_fault_code    <= w_fault_next;
            r_cycle_count   <= w_cycle_next;
`ifdef PC_RETIRE_COUNT_EN
            r_retired_count <= w_retired_next;
`endif
        end
    end

    // Next-state, next-datapath and commit logic
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_fault_next   = r_fault_code;
        w_cycle_next   = r_cycle_count;
        w_commit       = 1'b0;
`ifdef PC_RETIRE_COUNT_EN
        w_retired_next = r_retired_count;
`endif
        case (r_state)
            ST_RUN: begin
                w_commit     = !imem_error && instr_valid && !dmem_error;
                w_cycle_next = (r_cycle_count == {64{1'b1}}) ? r_cycle_count
                                                             : r_cycle_count + 64'd1;
`ifdef PC_RETIRE_COUNT_EN
                if (w_commit && (r_retired_count != {64{1'b1}})) begin
                    w_retired_next = r_retired_count + 64'd1;
                end
`endif
                // Fault classification order matters: an instruction-side
                // address fault masks an illegal-instruction report.
                if (imem_error) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = C_STAT_ADR;
                end else if (!instr_valid) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = C_STAT_INS;
                end else if (dmem_error) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = C_STAT_ADR;
                end else if (icode == 4'h0) begin
                    // Halt keeps pc at the halt instruction itself
                    w_state_next = ST_HALT;
                end else begin
                    w_pc_next = updated_pc;
                end
            end
            default: begin
                // IDLE, HALT and FAULT are frozen until start; errors ignored
                if (start) begin
                    w_state_next   = ST_RUN;
                    w_pc_next      = start_pc;
                    w_fault_next   = C_STAT_IDLE;
                    w_cycle_next   = 64'd0;
`ifdef PC_RETIRE_COUNT_EN
                    w_retired_next = 64'd0;
`endif
                end
            end
        endcase
    end

    always_comb begin
        case (r_state)
            ST_IDLE: stat = C_STAT_IDLE;
            ST_RUN:  stat = C_STAT_AOK;
            ST_HALT: stat = C_STAT_HLT;
            default: stat = r_fault_code;
        endcase
    end

    assign pc            = r_pc;
    assign commit        = w_commit;
    assign cycle_count   = r_cycle_count;
`ifdef PC_RETIRE_COUNT_EN
    assign retired_count = r_retired_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Directed scenarios
//               followed by randomized instruction streams, each cycle checked
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] start_pc;
    logic [63:0] updated_pc;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        dmem_error;
    logic [63:0] pc;
    logic        commit;
    logic [2:0]  stat;
    logic [63:0] cycle_count;
    logic [63:0] retired_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural status plus counters
    logic [63:0] m_pc      = 64'd0;
    logic [2:0]  m_stat    = 3'd0;
    logic [63:0] m_cycles  = 64'd0;
    logic [63:0] m_retired = 64'd0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .updated_pc  (updated_pc),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .pc          (pc),
        .commit      (commit),
        .stat        (stat),
        .cycle_count (cycle_count)
`ifdef PC_RETIRE_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

`ifndef PC_RETIRE_COUNT_EN
    assign retired_count = 64'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (v == {64{1'b1}}) ? v : v + 64'd1;
    endfunction

    // One clock cycle: drive, check commit, clock, advance model, check state
    task automatic step(input bit r, input bit s, input logic [63:0] spc,
                        input logic [63:0] upd, input logic [3:0] ic,
                        input bit v, input bit ie, input bit de);
        bit running;
        bit exp_commit;
        @(negedge clk);
        rst = r; start = s; start_pc = spc; updated_pc = upd;
        icode = ic; instr_valid = v; imem_error = ie; dmem_error = de;
        running    = (m_stat == 3'd1);
        exp_commit = running && !ie && v && !de;
        #1;
        chk("commit", {63'd0, commit}, {63'd0, exp_commit});
        @(posedge clk);
        if (r) begin
            m_pc = 64'd0; m_stat = 3'd0; m_cycles = 64'd0; m_retired = 64'd0;
        end else if (!running) begin
            if (s) begin
                m_pc = spc; m_stat = 3'd1; m_cycles = 64'd0; m_retired = 64'd0;
            end
        end else begin
            m_cycles = sat_inc(m_cycles);
            if (exp_commit) m_retired = sat_inc(m_retired);
            if (ie)              m_stat = 3'd3;
            else if (!v)         m_stat = 3'd4;
            else if (de)         m_stat = 3'd3;
            else if (ic == 4'h0) m_stat = 3'd2;
            else                 m_pc   = upd;
        end
        #1;
        chk("pc", pc, m_pc);
        chk("stat", {61'd0, stat}, {61'd0, m_stat});
        chk("cycle_count", cycle_count, m_cycles);
`ifdef PC_RETIRE_COUNT_EN
        chk("retired_count", retired_count, m_retired);
`endif
    endtask

    // Normal (non-halt, non-fault) instruction with given next PC
    task automatic run(input logic [63:0] upd);
        step(0, 0, 64'd0, upd, 4'h3, 1, 0, 0);
    endtask

    task automatic go(input logic [63:0] spc);
        step(0, 1, spc, 64'd0, 4'h3, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = '0; updated_pc = '0;
        icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;

        // Reset, including reset with start asserted
        step(1, 1, 64'h55, 64'h66, 4'h3, 1, 1, 1);
        chk("reset_pc", pc, 64'd0);
        chk("reset_stat", {61'd0, stat}, 64'd0);

        // Start scenario
        step(0, 1, 64'h100, 64'h10A, 4'h3, 1, 0, 0);
        chk("start_pc", pc, 64'h100);
        chk("start_stat", {61'd0, stat}, 64'd1);
        step(0, 1, 64'h999, 64'h10A, 4'h3, 1, 0, 0);   // start ignored in RUN
        chk("first_update_pc", pc, 64'h10A);
        chk("first_cycle_count", cycle_count, 64'd1);

        // Halt scenario
        run(64'h20);
        step(0, 0, 64'd0, 64'h44, 4'h0, 1, 0, 0);
        chk("halt_pc", pc, 64'h20);
        chk("halt_stat", {61'd0, stat}, 64'd2);
        step(0, 0, 64'd0, 64'h44, 4'h3, 1, 1, 1);       // frozen
        go(64'd0);
        chk("restart_cycles", cycle_count, 64'd0);

        // Priority scenario: imem_error beats invalid instruction
        step(0, 0, 64'd0, 64'h8, 4'h3, 0, 1, 0);
        chk("prio_stat", {61'd0, stat}, 64'd3);
        step(0, 1, 64'h30, 64'd0, 4'h3, 1, 1, 1);       // start with errors in FAULT
        step(0, 0, 64'd0, 64'h8, 4'h3, 0, 0, 1);
        chk("ins_stat", {61'd0, stat}, 64'd4);

        // Data-fault scenario
        go(64'h58);
        step(0, 0, 64'd0, 64'h60, 4'h5, 1, 0, 1);
        chk("dfault_pc", pc, 64'h58);
        chk("dfault_stat", {61'd0, stat}, 64'd3);

        // Wrap, then reset together with start mid-RUN
        go(64'h0);
        run(64'hFFFF_FFFF_FFFF_FFFF);
        run(64'd0);
        chk("wrap_pc", pc, 64'd0);
        run(64'h1234);
        step(1, 1, 64'h77, 64'h88, 4'h3, 1, 0, 0);
        chk("rst_mid_run_stat", {61'd0, stat}, 64'd0);

        // Saturation of cycle_count
        go(64'h400);
        run(64'h408);
        @(negedge clk);
        force dut.r_cycle_count = {64{1'b1}};
        #1;
        release dut.r_cycle_count;
        m_cycles = {64{1'b1}};
        run(64'h410);
        chk("cycle_saturated", cycle_count, {64{1'b1}});

        // Randomized instruction streams
        for (int i = 0; i < 400; i++) begin
            bit          r, s, v, ie, de;
            logic [3:0]  ic;
            logic [63:0] spc, upd;
            r   = ($urandom_range(0, 63) == 0);
            s   = ($urandom_range(0, 5) == 0);
            v   = ($urandom_range(0, 15) != 0);
            ie  = ($urandom_range(0, 19) == 0);
            de  = ($urandom_range(0, 19) == 0);
            ic  = ($urandom_range(0, 11) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            spc = {$urandom, $urandom};
            upd = {$urandom, $urandom};
            step(r, s, spc, upd, ic, v, ie, de);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
